logs_mixer: RTL and testbench

//  Downstream stage of the logs_nco bank: takes the V square waves, applies a
//  per-voice gated linear attack/release envelope, sums the enveloped voices

---
 rtl/logs_mixer_if.sv | 17 +
 rtl/logs_mixer.sv | 72 +++++++
 tb/tb_logs_mixer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logs_mixer_if.sv
// Voice bus between the NCO bank/gate logic (master) and the mixer (slave):
// square waves, gates and step strobe in, enveloped level and PDM bit out.
interface logs_mixer_if #(
  parameter int V  = 8,
  parameter int EW = 4
);
  localparam int SW = EW + $clog2(V);

  logic          step;
  logic [V-1:0]  snd_in;
  logic [V-1:0]  gate;
  logic [SW-1:0] level;
  logic          pdm;

  modport master (output step, snd_in, gate, input level, pdm);
  modport slave  (input step, snd_in, gate, output level, pdm);
endinterface

// File: rtl/logs_mixer.sv
// Per-voice linear attack/release envelopes, enveloped sum and 1-bit sigma-delta.
// Latency: env/snd_in edge t -> level at t+1 -> pdm at t+2; no backpressure.
module logs_mixer #(
  parameter int V       = 8,
  parameter int EW      = 4,
  parameter int ENV_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  logs_mixer_if.slave  bus
);
  localparam int SW = EW + $clog2(V);
  localparam int PW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [EW-1:0] ENV_MAX = {EW{1'b1}};

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [EW-1:0] env_q [V];
  logic [EW-1:0] env_d [V];
  logic [SW-1:0] level_q, level_d;
  logic [SW-1:0] acc_q;
  logic [SW:0]   acc_sum;
  logic          pdm_q;

  assign tick = bus.step && (presc_q == PW'(ENV_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (tick)          presc_d = '0;
    else if (bus.step) presc_d = presc_q + 1'b1;
  end

  // Envelopes saturate at both ends; only the tick moves them.
  always_comb begin
    for (int v = 0; v < V; v++) begin
      env_d[v] = env_q[v];
      if (tick) begin
        if (bus.gate[v] && env_q[v] != ENV_MAX) env_d[v] = env_q[v] + 1'b1;
        else if (!bus.gate[v] && env_q[v] != '0) env_d[v] = env_q[v] - 1'b1;
      end
    end
  end

  always_comb begin
    level_d = '0;
    for (int v = 0; v < V; v++) begin
      if (bus.snd_in[v]) level_d = level_d + SW'(env_q[v]);
    end
  end

  // Carry out of the phase accumulator is the PDM bit; duty = level / 2^SW.
  assign acc_sum = {1'b0, acc_q} + {1'b0, level_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      for (int v = 0; v < V; v++) env_q[v] <= '0;
      level_q <= '0;
      acc_q   <= '0;
      pdm_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      for (int v = 0; v < V; v++) env_q[v] <= env_d[v];
      level_q <= level_d;
      acc_q   <= acc_sum[SW-1:0];
      pdm_q   <= acc_sum[SW];
    end
  end

  assign bus.level = level_q;
  assign bus.pdm   = pdm_q;
endmodule

// File: tb/tb_logs_mixer.sv
// Randomised and directed checks of logs_mixer against a per-clock behavioural model.
module tb_logs_mixer;
  localparam int V = 8, EW = 4, ENV_DIV = 4, SW = 7;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state, advanced once per rising edge from the documented rules.
  int m_env [V];
  int m_presc, m_level, m_acc, m_pdm;

  always #5 clk = ~clk;

  logs_mixer_if #(.V(V), .EW(EW)) bus ();

  logs_mixer #(.V(V), .EW(EW), .ENV_DIV(ENV_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic model_update();
    int nl, s;
    if (reset) begin
      for (int v = 0; v < V; v++) m_env[v] = 0;
      m_presc = 0; m_level = 0; m_acc = 0; m_pdm = 0;
    end else begin
      nl = 0;
      for (int v = 0; v < V; v++) if (bus.snd_in[v]) nl += m_env[v];
      s       = m_acc + m_level;
      m_pdm   = (s >= (1 << SW)) ? 1 : 0;
      m_acc   = s % (1 << SW);
      m_level = nl;
      if (bus.step) begin
        if (m_presc == ENV_DIV - 1) begin
          m_presc = 0;
          for (int v = 0; v < V; v++) begin
            if (bus.gate[v]) m_env[v] = (m_env[v] < 15) ? m_env[v] + 1 : 15;
            else             m_env[v] = (m_env[v] > 0)  ? m_env[v] - 1 : 0;
          end
        end else begin
          m_presc++;
        end
      end
    end
  endtask

  // Inputs are driven at the falling edge; outputs are read there too.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic st, input logic [V-1:0] g, input logic [V-1:0] s);
    reset = r; bus.step = st; bus.gate = g; bus.snd_in = s;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom), V'($urandom), V'($urandom));
      cycle();
      n_checks++;
      if (bus.level !== 7'd0 || bus.pdm !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out cyc%0d: level=%0d pdm=%b, want 0/0", i, bus.level, bus.pdm);
      end
    end
    drive(1'b0, 1'b0, '0, 8'hFF);
    cycle();
    cycle();
    n_checks++;
    if (bus.level !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_env: level=%0d with all snd on, want 0", bus.level);
    end
  endtask

  task automatic test_attack();
    drive(1'b1, 1'b0, '0, '0);
    cycle();
    drive(1'b0, 1'b1, 8'h01, 8'h01);
    for (int i = 1; i <= 75; i++) begin
      cycle();
      n_checks++;
      if (bus.level !== 7'(m_level) || bus.pdm !== 1'(m_pdm)) begin
        n_fail++;
        $display("FAIL attack cyc%0d: level=%0d pdm=%b, want %0d/%0d", i, bus.level, bus.pdm, m_level, m_pdm);
      end
      if (i == 60 || i == 61) begin
        n_checks++;
        if (bus.level !== ((i == 60) ? 7'd14 : 7'd15)) begin
          n_fail++;
          $display("FAIL attack_edge cyc%0d: level=%0d, want %0d", i, bus.level, (i == 60) ? 14 : 15);
        end
      end
    end
    n_checks++;
    if (bus.level !== 7'd15) begin
      n_fail++;
      $display("FAIL attack_hold: level=%0d, want 15", bus.level);
    end
  endtask

  task automatic test_duty();
    int ones;
    ones = 0;
    for (int i = 0; i < 128; i++) begin
      cycle();
      ones += int'(bus.pdm);
    end
    n_checks++;
    if (ones != 15) begin
      n_fail++;
      $display("FAIL duty_15: ones=%0d per 128, want 15", ones);
    end
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    for (int i = 0; i < 70; i++) cycle();
    n_checks++;
    if (bus.level !== 7'd120) begin
      n_fail++;
      $display("FAIL full_level: level=%0d, want 120", bus.level);
    end
    ones = 0;
    for (int i = 0; i < 128; i++) begin
      cycle();
      ones += int'(bus.pdm);
    end
    n_checks++;
    if (ones != 120) begin
      n_fail++;
      $display("FAIL duty_120: ones=%0d per 128, want 120", ones);
    end
  endtask

  task automatic test_release();
    int ones;
    drive(1'b0, 1'b1, 8'h00, 8'h01);
    for (int i = 1; i <= 80; i++) begin
      cycle();
      n_checks++;
      if (bus.level !== 7'(m_level) || bus.pdm !== 1'(m_pdm)) begin
        n_fail++;
        $display("FAIL release cyc%0d: level=%0d pdm=%b, want %0d/%0d", i, bus.level, bus.pdm, m_level, m_pdm);
      end
    end
    n_checks++;
    if (bus.level !== 7'd0) begin
      n_fail++;
      $display("FAIL release_floor: level=%0d, want 0", bus.level);
    end
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      ones += int'(bus.pdm);
    end
    n_checks++;
    if (ones != 0 || bus.level !== 7'd0) begin
      n_fail++;
      $display("FAIL release_nowrap: ones=%0d level=%0d, want 0/0", ones, bus.level);
    end
  endtask

  task automatic test_step_gating();
    logic [V-1:0] s, prev;
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    for (int i = 0; i < 20; i++) cycle();
    prev = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      s = V'($urandom);
      drive(1'b0, 1'b0, 8'hFF, s);
      cycle();
      n_checks++;
      if (bus.level !== 7'(5 * $countones(s)) || bus.pdm !== 1'(m_pdm)) begin
        n_fail++;
        $display("FAIL step_gate cyc%0d: level=%0d pdm=%b, want %0d/%0d", i, bus.level, bus.pdm, 5 * $countones(s), m_pdm);
      end
      prev = s;
    end
    drive(1'b0, 1'b0, 8'hFF, 8'hFF);
    cycle();
    n_checks++;
    if (bus.level !== 7'd40) begin
      n_fail++;
      $display("FAIL step_frozen: level=%0d prev_snd=%h, want 40", bus.level, prev);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, '0, '0);
    cycle();
    drive(1'b0, 1'b1, 8'h01, 8'h01);
    for (int i = 0; i < 30; i++) cycle();
    n_checks++;
    if (bus.level !== 7'd7) begin
      n_fail++;
      $display("FAIL mid_pre: level=%0d, want 7", bus.level);
    end
    drive(1'b1, 1'b1, 8'h01, 8'h01);
    cycle();
    n_checks++;
    if (bus.level !== 7'd0 || bus.pdm !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: level=%0d pdm=%b, want 0/0", bus.level, bus.pdm);
    end
    drive(1'b0, 1'b1, 8'h01, 8'h01);
    for (int i = 1; i <= 9; i++) begin
      cycle();
      n_checks++;
      if (bus.level !== 7'((i >= 5) ? (i - 1) / 4 : 0) || bus.pdm !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_restart cyc%0d: level=%0d pdm=%b, want %0d/0", i, bus.level, bus.pdm, (i >= 5) ? (i - 1) / 4 : 0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0), 1'($urandom), V'($urandom), V'($urandom));
      cycle();
      n_checks++;
      if (bus.level !== 7'(m_level) || bus.pdm !== 1'(m_pdm)) begin
        n_fail++;
        $display("FAIL random cyc%0d: level=%0d pdm=%b, want %0d/%0d", i, bus.level, bus.pdm, m_level, m_pdm);
      end
    end
  endtask

  initial begin
    for (int v = 0; v < V; v++) m_env[v] = 0;
    m_presc = 0; m_level = 0; m_acc = 0; m_pdm = 0;
    drive(1'b1, 1'b0, '0, '0);
    @(negedge clk);
    test_reset();
    test_attack();
    test_duty();
    test_release();
    test_step_gating();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
